// File: rtl/ecc_mem_arbiter_pkg.sv
// Hamming(12,8) code helpers and FSM state type shared by the arbiter and its decoder.
// Codeword bit c[i] carries Hamming position i+1; parity sits at positions 1, 2, 4, 8.
package ecc_pkg;

  localparam int CW_W   = 12;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, RD, SCRB, WB} state_t;

  function automatic logic [CW_W-1:0] ecc_encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] c;
    c     = '0;
    c[2]  = d[0];
    c[4]  = d[1];
    c[5]  = d[2];
    c[6]  = d[3];
    c[8]  = d[4];
    c[9]  = d[5];
    c[10] = d[6];
    c[11] = d[7];
    c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
    return c;
  endfunction

  function automatic logic [3:0] ecc_syndrome(input logic [CW_W-1:0] c);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < CW_W; i++) begin
      if (c[i]) s = s ^ 4'(i + 1);
    end
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] ecc_extract(input logic [CW_W-1:0] c);
    return {c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
  endfunction

endpackage

// File: rtl/ecc_mem_arbiter_decoder.sv
// Combinational Hamming(12,8) decoder: single-bit correction, syndromes 13..15 flagged
// uncorrectable and passed through unmodified.
module ecc_decoder
  import ecc_pkg::*;
(
  input  logic [CW_W-1:0]   cw,
  output logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   cw_fix,
  output logic              corrected,
  output logic              uncorr
);

  logic [3:0] syn;

  assign syn = ecc_syndrome(cw);

  always_comb begin
    corrected = (syn != 4'd0) && (syn <= 4'd12);
    uncorr    = (syn >= 4'd13);
    cw_fix    = cw;
    if (corrected) cw_fix = cw ^ (CW_W'(1) << (syn - 4'd1));
    data      = ecc_extract(cw_fix);
  end

endmodule

// File: rtl/ecc_mem_arbiter.sv
// Two-port round-robin arbiter over an ECC-protected array with writeback and idle scrubbing.
// Writes complete in the grant cycle; reads return rvalid two cycles after gnt; requests wait while busy.
module ecc_mem_arbiter
  import ecc_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int AW             = $clog2(DEPTH),
  parameter int SCRUB_INTERVAL = 64,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              rd_corrected,
  output logic              rd_uncorr,
  input  logic              scrub_en,
  input  logic [CW_W-1:0]   inj_mask,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic              busy
);

  localparam int IW = $clog2(SCRUB_INTERVAL) + 1;

  state_t             state;
  logic               last_b;
  logic               lat_b;
  logic [AW-1:0]      lat_addr;
  logic [AW-1:0]      scrub_addr;
  logic [IW-1:0]      idle_cnt;
  logic [CW_W-1:0]    mem [DEPTH];
  logic [CW_W-1:0]    rd_cw;
  logic [CW_W-1:0]    wb_cw;

  logic               idle_ok, any_gnt, scrub_go;
  logic               g_we;
  logic [AW-1:0]      g_addr;
  logic [DATA_W-1:0]  g_wdata;
  logic               mem_we, mem_re;
  logic [AW-1:0]      mem_waddr, mem_raddr;
  logic [CW_W-1:0]    mem_wdat;
  logic [DATA_W-1:0]  dec_data;
  logic [CW_W-1:0]    dec_cw;
  logic               dec_corr, dec_uncorr;

  // Grants are combinational so that we/addr/wdata are sampled in the gnt cycle itself.
  assign idle_ok  = (state == IDLE) && !rst;
  assign a_gnt    = idle_ok && a_req && (!b_req || last_b);
  assign b_gnt    = idle_ok && b_req && (!a_req || !last_b);
  assign any_gnt  = a_gnt || b_gnt;
  assign g_we     = b_gnt ? b_we    : a_we;
  assign g_addr   = b_gnt ? b_addr  : a_addr;
  assign g_wdata  = b_gnt ? b_wdata : a_wdata;
  assign scrub_go = idle_ok && !a_req && !b_req && scrub_en &&
                    (idle_cnt == IW'(SCRUB_INTERVAL - 1));
  assign busy     = (state != IDLE);

  assign mem_we    = (any_gnt && g_we) || ((state == WB) && !rst);
  assign mem_waddr = (state == WB) ? lat_addr : g_addr;
  assign mem_wdat  = (state == WB) ? wb_cw : (ecc_encode(g_wdata) ^ inj_mask);
  assign mem_re    = (any_gnt && !g_we) || scrub_go;
  assign mem_raddr = scrub_go ? scrub_addr : g_addr;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdat;
    if (mem_re) rd_cw <= mem[mem_raddr];
  end

  ecc_decoder u_dec (
    .cw        (rd_cw),
    .data      (dec_data),
    .cw_fix    (dec_cw),
    .corrected (dec_corr),
    .uncorr    (dec_uncorr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_b       <= 1'b1;
      lat_b        <= 1'b0;
      lat_addr     <= '0;
      scrub_addr   <= '0;
      idle_cnt     <= '0;
      wb_cw        <= '0;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      rd_corrected <= 1'b0;
      rd_uncorr    <= 1'b0;
      corr_cnt     <= '0;
      uncorr_cnt   <= '0;
    end else begin
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      rd_corrected <= 1'b0;
      rd_uncorr    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_gnt) begin
            last_b   <= b_gnt;
            idle_cnt <= '0;
            if (!g_we) begin
              lat_b    <= b_gnt;
              lat_addr <= g_addr;
              state    <= RD;
            end
          end else if (scrub_go) begin
            idle_cnt <= '0;
            lat_addr <= scrub_addr;
            state    <= SCRB;
          end else if (scrub_en) begin
            idle_cnt <= idle_cnt + 1'b1;
          end else begin
            idle_cnt <= '0;
          end
        end
        RD, SCRB: begin
          if (state == RD) begin
            if (lat_b) begin
              b_rvalid <= 1'b1;
              b_rdata  <= dec_data;
            end else begin
              a_rvalid <= 1'b1;
              a_rdata  <= dec_data;
            end
            rd_corrected <= dec_corr;
            rd_uncorr    <= dec_uncorr;
          end else begin
            scrub_addr <= scrub_addr + 1'b1;
          end
          wb_cw <= dec_cw;
          if (dec_corr) begin
            if (corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
            state <= WB;
          end else begin
            if (dec_uncorr && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + 1'b1;
            state <= IDLE;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_mem_arbiter.sv
// Scoreboard bench for ecc_mem_arbiter: expected reads queued at grant, checked at rvalid.
module tb_ecc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [3:0]  a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0]  a_rdata, b_rdata;
  logic        rd_corrected, rd_uncorr, scrub_en, busy;
  logic [11:0] inj_mask;
  logic [15:0] corr_cnt, uncorr_cnt;

  typedef struct {
    bit         port;
    logic [7:0] data;
    bit         corr;
    bit         unc;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   ord[4];
  int   ngot;

  ecc_mem_arbiter #(.DEPTH(16), .SCRUB_INTERVAL(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .rd_corrected(rd_corrected), .rd_uncorr(rd_uncorr),
    .scrub_en(scrub_en), .inj_mask(inj_mask),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (a_rvalid || b_rvalid)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rvalid: a_rvalid=%0b b_rvalid=%0b cyc=%0d, none expected",
                 a_rvalid, b_rvalid, cyc);
      end else begin
        e = q.pop_front();
        if ((a_rvalid && b_rvalid) || (b_rvalid != e.port) ||
            ((b_rvalid ? b_rdata : a_rdata) !== e.data) ||
            (rd_corrected !== e.corr) || (rd_uncorr !== e.unc) || (cyc != e.cyc)) begin
          fails++;
          $display("FAIL read_result: got port=%0b data=%02h corr=%0b unc=%0b cyc=%0d, want port=%0b data=%02h corr=%0b unc=%0b cyc=%0d",
                   b_rvalid, (b_rvalid ? b_rdata : a_rdata), rd_corrected, rd_uncorr, cyc,
                   e.port, e.data, e.corr, e.unc, e.cyc);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_access(input bit port, input bit we, input logic [3:0] addr,
                           input logic [7:0] d, input logic [11:0] mask,
                           input logic [7:0] exp_d, input bit exp_c, input bit exp_u);
    int n;
    bit got;
    @(negedge clk);
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = d; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = d; end
    inj_mask = mask;
    got = 0;
    n   = 0;
    while (!got && n < 40) begin
      #1;
      if ((port ? b_gnt : a_gnt) === 1'b1) got = 1;
      else begin @(negedge clk); n++; end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL gnt_timeout: port=%0b addr=%0d no grant within %0d cycles", port, addr, n);
    end else if (!we) begin
      q.push_back('{port, exp_d, exp_c, exp_u, cyc + 2});
    end
    @(negedge clk);
    if (port) b_req = 0; else a_req = 0;
    inj_mask = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d reads outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  // Hold both read requests and record the order of the first ngr grants.
  task automatic run_both(input logic [3:0] aa, input logic [7:0] ad, input bit ac,
                          input logic [3:0] ba, input logic [7:0] bd, input bit bc,
                          input int ngr);
    int n;
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = aa;
    b_req = 1; b_we = 0; b_addr = ba;
    ngot = 0;
    n    = 0;
    while (ngot < ngr && n < 80) begin
      #1;
      if (a_gnt === 1'b1) begin
        ord[ngot] = 0; ngot++;
        q.push_back('{1'b0, ad, ac, 1'b0, cyc + 2});
      end else if (b_gnt === 1'b1) begin
        ord[ngot] = 1; ngot++;
        q.push_back('{1'b1, bd, bc, 1'b0, cyc + 2});
      end
      @(negedge clk);
      n++;
    end
    a_req = 0; b_req = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; a_req = 1; b_req = 1; a_we = 1; b_we = 1;
    a_addr = '0; b_addr = '0; a_wdata = 8'hFF; b_wdata = 8'hFF;
    scrub_en = 0; inj_mask = '0;
    #12;
    tests++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      fails++; $display("FAIL reset_gnt: got %b, want 00", {a_gnt, b_gnt});
    end
    tests++;
    if ({a_rvalid, b_rvalid, a_rdata, b_rdata, rd_corrected, rd_uncorr, busy} !== 21'd0) begin
      fails++; $display("FAIL reset_outputs: got %h, want 0",
                        {a_rvalid, b_rvalid, a_rdata, b_rdata, rd_corrected, rd_uncorr, busy});
    end
    a_req = 0; b_req = 0;
    @(negedge clk);
    rst = 0;
    #1;
    tests++;
    if ({corr_cnt, uncorr_cnt, busy} !== 33'd0) begin
      fails++; $display("FAIL reset_counters: got corr=%0d uncorr=%0d busy=%0b, want 0 0 0",
                        corr_cnt, uncorr_cnt, busy);
    end
  endtask

  task automatic test_arbitration();
    do_access(1, 1, 4'd1, 8'h11, 12'h0, 8'h0, 0, 0);
    do_access(1, 1, 4'd2, 8'h22, 12'h0, 8'h0, 0, 0);
    run_both(4'd1, 8'h11, 0, 4'd2, 8'h22, 0, 4);
    tests++;
    if (ngot != 4) begin
      fails++; $display("FAIL arb_grants: got %0d grants, want 4", ngot);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (ord[i] != bit'(i % 2)) begin
          fails++; $display("FAIL arb_order[%0d]: got %s, want %s", i,
                            ord[i] ? "B" : "A", (i % 2) ? "B" : "A");
        end
      end
    end
    wait_drain();
  endtask

  task automatic test_basic_rw();
    do_access(0, 1, 4'd3, 8'hA5, 12'h0, 8'h0, 0, 0);
    do_access(0, 0, 4'd3, 8'h00, 12'h0, 8'hA5, 0, 0);
    wait_drain();
  endtask

  task automatic test_correct();
    do_access(0, 1, 4'd5, 8'h3C, 12'h010, 8'h0, 0, 0);
    do_access(0, 0, 4'd5, 8'h00, 12'h0, 8'h3C, 1, 0);
    @(negedge clk); #1;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL wb_busy: got %0b, want 1", busy); end
    @(negedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL wb_done: got %0b, want 0", busy); end
    tests++;
    if (corr_cnt !== 16'd1) begin fails++; $display("FAIL corr_cnt_1: got %0d, want 1", corr_cnt); end
    do_access(0, 0, 4'd5, 8'h00, 12'h0, 8'h3C, 0, 0);
    wait_drain();
    tests++;
    if (corr_cnt !== 16'd1) begin fails++; $display("FAIL corr_cnt_stay: got %0d, want 1", corr_cnt); end
  endtask

  task automatic test_uncorrectable();
    // Positions 4 and 9 flipped: p4 and d4, so the raw data reads back as 0x4A.
    do_access(0, 1, 4'd7, 8'h5A, 12'h108, 8'h0, 0, 0);
    do_access(0, 0, 4'd7, 8'h00, 12'h0, 8'h4A, 0, 1);
    @(negedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL uncorr_no_wb: busy got %0b, want 0", busy); end
    tests++;
    if (uncorr_cnt !== 16'd1) begin fails++; $display("FAIL uncorr_cnt: got %0d, want 1", uncorr_cnt); end
    tests++;
    if (corr_cnt !== 16'd1) begin fails++; $display("FAIL uncorr_corr_cnt: got %0d, want 1", corr_cnt); end
  endtask

  task automatic test_reset_in_wb();
    do_access(0, 1, 4'd9, 8'h77, 12'h001, 8'h0, 0, 0);
    do_access(0, 0, 4'd9, 8'h00, 12'h0, 8'h77, 1, 0);
    @(negedge clk); #1;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL rst_wb_state: busy got %0b, want 1", busy); end
    rst = 1;
    #1;
    tests++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, rd_corrected, rd_uncorr,
         corr_cnt, uncorr_cnt, busy} !== 55'd0) begin
      fails++; $display("FAIL rst_async: outputs not cleared, corr=%0d uncorr=%0d busy=%0b",
                        corr_cnt, uncorr_cnt, busy);
    end
    @(negedge clk);
    rst = 0;
    // Writeback was aborted, so addr 9 must still need correction.
    run_both(4'd9, 8'h77, 1, 4'd3, 8'hA5, 0, 2);
    tests++;
    if (ngot != 2 || ord[0] != 1'b0) begin
      fails++; $display("FAIL rst_first_gnt: got %0d grants first=%s, want 2 first=A",
                        ngot, ord[0] ? "B" : "A");
    end
    wait_drain();
    tests++;
    if (corr_cnt !== 16'd1 || uncorr_cnt !== 16'd0) begin
      fails++; $display("FAIL rst_counters: got corr=%0d uncorr=%0d, want 1 0", corr_cnt, uncorr_cnt);
    end
  endtask

  task automatic test_scrub();
    int n;
    pulse_reset();
    for (int i = 0; i < 16; i++)
      do_access(0, 1, 4'(i), 8'(i * 7 + 1), (i == 0) ? 12'h800 : 12'h000, 8'h0, 0, 0);
    @(negedge clk);
    scrub_en = 1;
    n = 0;
    while (corr_cnt !== 16'd1 && n < 40) begin @(negedge clk); n++; end
    scrub_en = 0;
    tests++;
    if (corr_cnt !== 16'd1) begin
      fails++; $display("FAIL scrub_corr: corr_cnt got %0d after %0d cycles, want 1", corr_cnt, n);
    end
    tests++;
    if (dut.scrub_addr !== 4'd1) begin
      fails++; $display("FAIL scrub_addr: got %0d, want 1", dut.scrub_addr);
    end
    repeat (4) @(negedge clk);
    do_access(0, 0, 4'd0, 8'h00, 12'h0, 8'h01, 0, 0);
    wait_drain();
    tests++;
    if (corr_cnt !== 16'd1 || uncorr_cnt !== 16'd0) begin
      fails++; $display("FAIL scrub_final: got corr=%0d uncorr=%0d, want 1 0", corr_cnt, uncorr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_basic_rw();
    test_correct();
    test_uncorrectable();
    test_reset_in_wb();
    test_scrub();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
